// File: rtl/mem_arbiter_pkg.sv
// Shared types for the data-side memory arbiter: region codes and requester IDs.
package mem_arbiter_pkg;

  localparam int XLEN = 32;

  typedef enum logic [2:0] {
    REGION_NONE = 3'd0,
    REGION_DMEM = 3'd1,
    REGION_IMEM = 3'd2,
    REGION_BIOS = 3'd3,
    REGION_IO   = 3'd4
  } region_e;

  typedef enum logic {
    REQ_CPU = 1'b0,
    REQ_DMA = 1'b1
  } req_id_e;

endpackage

// File: rtl/mem_region_decode.sv
// Address-map decode from the top nibble of a byte address.
// IMEM is write-only through this port, so a read of 0x2xxx_xxxx is unmapped.
module mem_region_decode
  import mem_arbiter_pkg::*;
(
  input  logic [3:0] addr_hi_i,
  input  logic [3:0] wmask_i,
  output region_e    region_o,
  output logic       dmem_hit_o,
  output logic       imem_hit_o,
  output logic       err_o
);

  logic is_write_s;

  // Region lookup; 0x3 writes hit DMEM and IMEM together
  always_comb begin
    is_write_s = (wmask_i != 4'd0);
    dmem_hit_o = (addr_hi_i[3:2] == 2'b00) && addr_hi_i[0];
    imem_hit_o = is_write_s && (addr_hi_i[3:1] == 3'b001);
    if (dmem_hit_o) begin
      region_o = REGION_DMEM;
    end else if (imem_hit_o) begin
      region_o = REGION_IMEM;
    end else if (addr_hi_i == 4'b0100) begin
      region_o = REGION_BIOS;
    end else if (addr_hi_i == 4'b1000) begin
      region_o = REGION_IO;
    end else begin
      region_o = REGION_NONE;
    end
    err_o = (region_o == REGION_NONE);
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing the data-side memory port between CPU and DMA,
// with a starvation bound and a one-entry read-response pipeline.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int XLEN     = mem_arbiter_pkg::XLEN,
  parameter int ADDR_W   = 14,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req_valid,
  output logic              cpu_req_ready,
  input  logic [XLEN-1:0]   cpu_addr,
  input  logic [XLEN-1:0]   cpu_wdata,
  input  logic [3:0]        cpu_wmask,
  output logic [XLEN-1:0]   cpu_rdata,
  output logic              cpu_rvalid,
  input  logic              dma_req_valid,
  output logic              dma_req_ready,
  input  logic [XLEN-1:0]   dma_addr,
  input  logic [XLEN-1:0]   dma_wdata,
  input  logic [3:0]        dma_wmask,
  output logic [XLEN-1:0]   dma_rdata,
  output logic              dma_rvalid,
  output logic [ADDR_W-1:0] mem_adr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [3:0]        dmem_we,
  output logic [3:0]        imem_we,
  output logic              io_en,
  output logic              io_we,
  input  logic [XLEN-1:0]   dmem_rdata,
  input  logic [XLEN-1:0]   bios_rdata,
  input  logic [XLEN-1:0]   io_rdata,
  output logic              addr_err
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);
  localparam logic [WAIT_W-1:0] WAIT_ONE = WAIT_W'(1);

  logic              cpu_v_s, dma_v_s, gnt_cpu_s, gnt_dma_s, gnt_any_s, is_read_s;
  logic [XLEN-1:0]   sel_addr_s, sel_wdata_s, rsp_data_s;
  logic [3:0]        sel_wmask_s;
  region_e           region_s;
  logic              dmem_hit_s, imem_hit_s, err_s;
  logic              unused_addr_s;

  req_id_e           last_grant_q, last_grant_d;
  logic [WAIT_W-1:0] cpu_wait_q, cpu_wait_d, dma_wait_q, dma_wait_d;
  logic              rd_pend_q, rd_pend_d;
  req_id_e           rd_owner_q, rd_owner_d;
  region_e           rd_region_q, rd_region_d;
  logic              addr_err_q, addr_err_d;
  logic [XLEN-1:0]   cpu_rdata_q, dma_rdata_q;

  // Arbitration: a starved requester wins outright, otherwise alternate on ties
  always_comb begin
    cpu_v_s   = cpu_req_valid & rst;
    dma_v_s   = dma_req_valid & rst;
    gnt_cpu_s = 1'b0;
    gnt_dma_s = 1'b0;
    if (cpu_v_s && dma_v_s) begin
      if (dma_wait_q == WAIT_MAX) begin
        gnt_dma_s = 1'b1;
      end else if (cpu_wait_q == WAIT_MAX) begin
        gnt_cpu_s = 1'b1;
      end else if (last_grant_q == REQ_DMA) begin
        gnt_cpu_s = 1'b1;
      end else begin
        gnt_dma_s = 1'b1;
      end
    end else begin
      gnt_cpu_s = cpu_v_s;
      gnt_dma_s = dma_v_s;
    end
    gnt_any_s   = gnt_cpu_s | gnt_dma_s;
    sel_addr_s  = gnt_dma_s ? dma_addr  : cpu_addr;
    sel_wdata_s = gnt_dma_s ? dma_wdata : cpu_wdata;
    sel_wmask_s = gnt_dma_s ? dma_wmask : cpu_wmask;
    is_read_s   = gnt_any_s && (sel_wmask_s == 4'd0);
  end

  assign unused_addr_s = ^{sel_addr_s[XLEN-5:ADDR_W+2], sel_addr_s[1:0]};

  mem_region_decode u_decode (
    .addr_hi_i  (sel_addr_s[XLEN-1:XLEN-4]),
    .wmask_i    (sel_wmask_s),
    .region_o   (region_s),
    .dmem_hit_o (dmem_hit_s),
    .imem_hit_o (imem_hit_s),
    .err_o      (err_s)
  );

  // Memory-side issue of the granted request
  always_comb begin
    cpu_req_ready = gnt_cpu_s;
    dma_req_ready = gnt_dma_s;
    mem_adr   = '0;
    mem_wdata = '0;
    dmem_we   = 4'd0;
    imem_we   = 4'd0;
    io_en     = 1'b0;
    io_we     = 1'b0;
    if (gnt_any_s) begin
      mem_adr   = sel_addr_s[ADDR_W+1:2];
      mem_wdata = sel_wdata_s;
      dmem_we   = dmem_hit_s ? sel_wmask_s : 4'd0;
      imem_we   = imem_hit_s ? sel_wmask_s : 4'd0;
      io_en     = (region_s == REGION_IO);
      io_we     = (region_s == REGION_IO) && !is_read_s;
    end else begin
      mem_adr   = '0;
    end
  end

  // Next-state for arbitration history, wait counters and the read pipeline
  always_comb begin
    last_grant_d = gnt_dma_s ? REQ_DMA : (gnt_cpu_s ? REQ_CPU : last_grant_q);
    if (!cpu_v_s || gnt_cpu_s) begin
      cpu_wait_d = '0;
    end else if (cpu_wait_q == WAIT_MAX) begin
      cpu_wait_d = cpu_wait_q;
    end else begin
      cpu_wait_d = cpu_wait_q + WAIT_ONE;
    end
    if (!dma_v_s || gnt_dma_s) begin
      dma_wait_d = '0;
    end else if (dma_wait_q == WAIT_MAX) begin
      dma_wait_d = dma_wait_q;
    end else begin
      dma_wait_d = dma_wait_q + WAIT_ONE;
    end
    rd_pend_d   = is_read_s;
    rd_owner_d  = gnt_dma_s ? REQ_DMA : REQ_CPU;
    rd_region_d = region_s;
    addr_err_d  = gnt_any_s & err_s;
  end

  // Read response: data arrives from the memories the cycle after the address
  always_comb begin
    case (rd_region_q)
      REGION_DMEM: rsp_data_s = dmem_rdata;
      REGION_BIOS: rsp_data_s = bios_rdata;
      REGION_IO:   rsp_data_s = io_rdata;
      default:     rsp_data_s = '0;
    endcase
    cpu_rvalid = rst & rd_pend_q & (rd_owner_q == REQ_CPU);
    dma_rvalid = rst & rd_pend_q & (rd_owner_q == REQ_DMA);
    cpu_rdata  = cpu_rvalid ? rsp_data_s : cpu_rdata_q;
    dma_rdata  = dma_rvalid ? rsp_data_s : dma_rdata_q;
    addr_err   = addr_err_q;
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      last_grant_q <= REQ_DMA;
      cpu_wait_q   <= '0;
      dma_wait_q   <= '0;
      rd_pend_q    <= 1'b0;
      rd_owner_q   <= REQ_CPU;
      rd_region_q  <= REGION_NONE;
      addr_err_q   <= 1'b0;
      cpu_rdata_q  <= '0;
      dma_rdata_q  <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      cpu_wait_q   <= cpu_wait_d;
      dma_wait_q   <= dma_wait_d;
      rd_pend_q    <= rd_pend_d;
      rd_owner_q   <= rd_owner_d;
      rd_region_q  <= rd_region_d;
      addr_err_q   <= addr_err_d;
      cpu_rdata_q  <= cpu_rdata;
      dma_rdata_q  <= dma_rdata;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter: decode, round-robin, starvation, reset.
module tb_mem_arbiter;

  logic        clk, rst;
  logic        cpu_req_valid, cpu_req_ready, cpu_rvalid;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic [3:0]  cpu_wmask;
  logic        dma_req_valid, dma_req_ready, dma_rvalid;
  logic [31:0] dma_addr, dma_wdata, dma_rdata;
  logic [3:0]  dma_wmask;
  logic [13:0] mem_adr;
  logic [31:0] mem_wdata, dmem_rdata, bios_rdata, io_rdata;
  logic [3:0]  dmem_we, imem_we;
  logic        io_en, io_we, addr_err;

  int checks = 0;
  int errors = 0;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_wmask(cpu_wmask), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
    .dma_req_valid(dma_req_valid), .dma_req_ready(dma_req_ready), .dma_addr(dma_addr),
    .dma_wdata(dma_wdata), .dma_wmask(dma_wmask), .dma_rdata(dma_rdata), .dma_rvalid(dma_rvalid),
    .mem_adr(mem_adr), .mem_wdata(mem_wdata), .dmem_we(dmem_we), .imem_we(imem_we),
    .io_en(io_en), .io_we(io_we), .dmem_rdata(dmem_rdata), .bios_rdata(bios_rdata),
    .io_rdata(io_rdata), .addr_err(addr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cpu_req_valid = 1'b0; dma_req_valid = 1'b0;
    cpu_wmask = 4'd0; dma_wmask = 4'd0;
  endtask

  task automatic test_reset();
    rst = 1'b0; idle();
    cyc(); cyc(); #1;
    checks++; if ({cpu_req_ready, dma_req_ready, cpu_rvalid, dma_rvalid, io_en, io_we, addr_err} !== 7'd0) begin
      errors++; $display("FAIL reset_flags got %b exp 0", {cpu_req_ready, dma_req_ready, cpu_rvalid, dma_rvalid, io_en, io_we, addr_err}); end
    checks++; if ({cpu_rdata, dma_rdata, mem_wdata} !== 96'd0) begin
      errors++; $display("FAIL reset_data got %h %h %h exp 0", cpu_rdata, dma_rdata, mem_wdata); end
    checks++; if ({mem_adr, dmem_we, imem_we} !== 22'd0) begin
      errors++; $display("FAIL reset_mem got %h %h %h exp 0", mem_adr, dmem_we, imem_we); end
    cyc(); rst = 1'b1;
  endtask

  task automatic test_cpu_read();
    cyc(); cpu_req_valid = 1'b1; cpu_addr = 32'h1000_0010; cpu_wmask = 4'd0; #1;
    checks++; if (cpu_req_ready !== 1'b1) begin errors++; $display("FAIL rd_cpu_ready got %b exp 1", cpu_req_ready); end
    checks++; if (mem_adr !== 14'd4) begin errors++; $display("FAIL rd_mem_adr got %0d exp 4", mem_adr); end
    checks++; if (dmem_we !== 4'd0) begin errors++; $display("FAIL rd_dmem_we got %b exp 0", dmem_we); end
    cyc(); cpu_req_valid = 1'b0; dmem_rdata = 32'hDEAD_BEEF; #1;
    checks++; if (cpu_rvalid !== 1'b1) begin errors++; $display("FAIL rd_cpu_rvalid got %b exp 1", cpu_rvalid); end
    checks++; if (cpu_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_cpu_rdata got %h exp deadbeef", cpu_rdata); end
    checks++; if (dma_rvalid !== 1'b0) begin errors++; $display("FAIL rd_dma_rvalid got %b exp 0", dma_rvalid); end
    cyc(); dmem_rdata = 32'h0; #1;
    checks++; if (cpu_rvalid !== 1'b0) begin errors++; $display("FAIL rd_rvalid_pulse got %b exp 0", cpu_rvalid); end
    checks++; if (cpu_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_rdata_hold got %h exp deadbeef", cpu_rdata); end
  endtask

  task automatic test_unmapped();
    cyc(); cpu_req_valid = 1'b1; cpu_addr = 32'h4000_0000; cpu_wmask = 4'hF; cpu_wdata = 32'h1234_0000; #1;
    checks++; if (cpu_req_ready !== 1'b1) begin errors++; $display("FAIL bios_wr_ready got %b exp 1", cpu_req_ready); end
    checks++; if ({dmem_we, imem_we, io_en, io_we} !== 10'd0) begin
      errors++; $display("FAIL bios_wr_en got %b %b %b %b exp 0", dmem_we, imem_we, io_en, io_we); end
    cyc(); idle(); dma_req_valid = 1'b1; dma_addr = 32'h7000_0000; dma_wmask = 4'd0; #1;
    checks++; if (addr_err !== 1'b0) begin errors++; $display("FAIL bios_wr_err got %b exp 0", addr_err); end
    checks++; if (cpu_rvalid !== 1'b0) begin errors++; $display("FAIL bios_wr_rvalid got %b exp 0", cpu_rvalid); end
    checks++; if (dma_req_ready !== 1'b1) begin errors++; $display("FAIL unm_ready got %b exp 1", dma_req_ready); end
    cyc(); idle(); dmem_rdata = 32'h1111_1111; bios_rdata = 32'h2222_2222; io_rdata = 32'h3333_3333; #1;
    checks++; if (dma_rvalid !== 1'b1) begin errors++; $display("FAIL unm_rvalid got %b exp 1", dma_rvalid); end
    checks++; if (dma_rdata !== 32'h0) begin errors++; $display("FAIL unm_rdata got %h exp 0", dma_rdata); end
    checks++; if (addr_err !== 1'b1) begin errors++; $display("FAIL unm_err got %b exp 1", addr_err); end
    cyc(); #1;
    checks++; if (addr_err !== 1'b0) begin errors++; $display("FAIL unm_err_pulse got %b exp 0", addr_err); end
  endtask

  task automatic test_round_robin();
    logic [31:0] exp_cpu, exp_dma;
    exp_cpu = 32'hDEAD_BEEF; exp_dma = 32'h0;
    for (int k = 0; k < 7; k++) begin
      cyc();
      cpu_req_valid = (k < 6); dma_req_valid = (k < 6);
      cpu_addr = 32'h1000_0040; dma_addr = 32'h4000_0080; cpu_wmask = 4'd0; dma_wmask = 4'd0;
      dmem_rdata = 32'hD000_0000 | 32'(k); bios_rdata = 32'hB000_0000 | 32'(k);
      #1;
      if (k < 6) begin
        checks++; if ({cpu_req_ready, dma_req_ready} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin
          errors++; $display("FAIL rr_grant k=%0d got %b%b exp cpu=%0d", k, cpu_req_ready, dma_req_ready, (k % 2 == 0)); end
        checks++; if (mem_adr !== ((k % 2 == 0) ? 14'd16 : 14'd32)) begin
          errors++; $display("FAIL rr_adr k=%0d got %0d", k, mem_adr); end
      end
      if (k > 0) begin
        if ((k - 1) % 2 == 0) exp_cpu = 32'hD000_0000 | 32'(k);
        else exp_dma = 32'hB000_0000 | 32'(k);
        checks++; if ({cpu_rvalid, dma_rvalid} !== (((k - 1) % 2 == 0) ? 2'b10 : 2'b01)) begin
          errors++; $display("FAIL rr_rvalid k=%0d got %b%b", k, cpu_rvalid, dma_rvalid); end
        checks++; if (cpu_rdata !== exp_cpu || dma_rdata !== exp_dma) begin
          errors++; $display("FAIL rr_rdata k=%0d got %h %h exp %h %h", k, cpu_rdata, dma_rdata, exp_cpu, exp_dma); end
      end
    end
    idle();
  endtask

  task automatic test_write();
    cyc(); cpu_req_valid = 1'b1; cpu_addr = 32'h3000_0008; cpu_wmask = 4'b0011; cpu_wdata = 32'hCAFE_F00D; #1;
    checks++; if (dmem_we !== 4'b0011 || imem_we !== 4'b0011) begin
      errors++; $display("FAIL wr_we got %b %b exp 0011 0011", dmem_we, imem_we); end
    checks++; if (mem_adr !== 14'd2) begin errors++; $display("FAIL wr_adr got %0d exp 2", mem_adr); end
    checks++; if (mem_wdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL wr_wdata got %h exp cafef00d", mem_wdata); end
    cyc(); idle(); #1;
    checks++; if ({cpu_rvalid, dma_rvalid, addr_err} !== 3'b000) begin
      errors++; $display("FAIL wr_no_rvalid got %b exp 000", {cpu_rvalid, dma_rvalid, addr_err}); end
  endtask

  task automatic test_io();
    cyc(); dma_req_valid = 1'b1; dma_addr = 32'h8000_0004; dma_wmask = 4'hF; dma_wdata = 32'h55; #1;
    checks++; if ({io_en, io_we, dmem_we} !== 6'b110000 || mem_adr !== 14'd1) begin
      errors++; $display("FAIL io_wr got en=%b we=%b dwe=%b adr=%0d exp 1 1 0 1", io_en, io_we, dmem_we, mem_adr); end
    cyc(); dma_wmask = 4'd0; #1;
    checks++; if ({io_en, io_we} !== 2'b10) begin errors++; $display("FAIL io_rd got %b%b exp 10", io_en, io_we); end
    cyc(); idle(); io_rdata = 32'h1234_5678; #1;
    checks++; if (dma_rvalid !== 1'b1 || dma_rdata !== 32'h1234_5678) begin
      errors++; $display("FAIL io_rdata got %b %h exp 1 12345678", dma_rvalid, dma_rdata); end
  endtask

  task automatic test_starvation();
    force dut.last_grant_q = mem_arbiter_pkg::REQ_DMA;
    for (int k = 1; k <= 5; k++) begin
      cyc(); cpu_req_valid = 1'b1; dma_req_valid = 1'b1;
      cpu_addr = 32'h1000_0000; dma_addr = 32'h1000_0004; cpu_wmask = 4'd0; dma_wmask = 4'd0; #1;
      checks++; if ({cpu_req_ready, dma_req_ready} !== ((k < 5) ? 2'b10 : 2'b01)) begin
        errors++; $display("FAIL starve pending=%0d got %b%b exp dma=%0d", k, cpu_req_ready, dma_req_ready, (k == 5)); end
    end
    cyc(); idle();
    release dut.last_grant_q;
    cyc();
  endtask

  task automatic test_reset_midop();
    cyc(); cpu_req_valid = 1'b1; cpu_addr = 32'h1000_0010; cpu_wmask = 4'd0; dmem_rdata = 32'hABCD_0123; #1;
    checks++; if (cpu_req_ready !== 1'b1) begin errors++; $display("FAIL mid_ready got %b exp 1", cpu_req_ready); end
    cyc(); idle(); rst = 1'b0;
    cyc(); rst = 1'b1; #1;
    checks++; if ({cpu_rvalid, dma_rvalid, addr_err} !== 3'b000) begin
      errors++; $display("FAIL mid_rvalid got %b exp 000", {cpu_rvalid, dma_rvalid, addr_err}); end
    checks++; if ({cpu_rdata, dma_rdata} !== 64'd0 || mem_adr !== 14'd0) begin
      errors++; $display("FAIL mid_outputs got %h %h %h exp 0", cpu_rdata, dma_rdata, mem_adr); end
    cyc(); cpu_req_valid = 1'b1; dma_req_valid = 1'b1; cpu_addr = 32'h1000_0000; dma_addr = 32'h1000_0000; #1;
    checks++; if ({cpu_req_ready, dma_req_ready} !== 2'b10) begin
      errors++; $display("FAIL mid_tie got %b%b exp 10", cpu_req_ready, dma_req_ready); end
    cyc(); idle(); cyc();
  endtask

  initial begin
    rst = 1'b0; idle();
    cpu_addr = 32'h0; cpu_wdata = 32'h0; dma_addr = 32'h0; dma_wdata = 32'h0;
    dmem_rdata = 32'h0; bios_rdata = 32'h0; io_rdata = 32'h0;
    test_reset();
    test_cpu_read();
    test_unmapped();
    test_round_robin();
    test_write();
    test_io();
    test_starvation();
    test_reset_midop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
